simon_data_in: RTL and testbench

SIMON_DATA_IN -- requirements
Module: simon_data_in

---
 rtl/simon_data_in.sv | 130 +++++++++++++
 tb/tb_simon_data_in.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/simon_data_in.sv
// simon_data_in: byte-serial loader for SIMON block and key frames.
// Optional macro SIMON_DATAIN_ERR_EN enables the errIN invalid-header pulse.
module simon_data_in #(
   parameter int N = 16,
   parameter int M = 4
) (
   input  logic                  clk,
   input  logic                  R,
   input  logic [7:0]            in,
   input  logic                  newIN,
   output logic                  inREADY,
   input  logic                  readData,
   input  logic                  readKey,
   output logic                  doneData,
   output logic                  doneKey,
   output logic [1:0][N-1:0]     BLOCK,
   output logic [M-1:0][N-1:0]   KEY,
   output logic [7:0]            info,
   output logic [7:0]            infoCOUNT,
   output logic                  errIN
);

   localparam int DB = 2 * N / 8;
   localparam int KB = M * N / 8;
   localparam int MB = (DB > KB) ? DB : KB;
   localparam int CW = $clog2(MB + 1);
   localparam int BW = 2 * N;
   localparam int KW = M * N;
   localparam logic [CW-1:0] DLAST = CW'(DB - 1);
   localparam logic [CW-1:0] KLAST = CW'(KB - 1);

   typedef enum logic [1:0] {WAIT, LOAD, HOLD} state_t;

   state_t          state;
   state_t          state_nx;
   logic [BW-1:0]   block_q;
   logic [KW-1:0]   key_q;
   logic [CW-1:0]   cnt;
   logic            is_key;
   logic            accept;
   logic            hdr_ok;
   logic            last;
   logic            clear;

   assign accept = newIN && inREADY;
   assign hdr_ok = (in[1:0] == 2'b01) || (in[1:0] == 2'b10);
   assign last   = (cnt == (is_key ? KLAST : DLAST));
   assign clear  = (state == HOLD) && (is_key ? readKey : readData);
   assign BLOCK  = block_q;
   assign KEY    = key_q;

   // State register.
   always_ff @(posedge clk) begin
      if (R) state <= WAIT;
      else   state <= state_nx;
   end

   // Next-state decode; input is refused while a frame is held.
   always_comb begin
      state_nx = state;
      inREADY  = 1'b1;
      unique case (state)
         WAIT: if (accept && hdr_ok) state_nx = LOAD;
         LOAD: if (accept && last)   state_nx = HOLD;
         HOLD: begin
            inREADY = 1'b0;
            if (clear) state_nx = WAIT;
         end
         default: state_nx = WAIT;
      endcase
   end

   // Header latch, payload shift-in, done flags and frame counter.
   always_ff @(posedge clk) begin
      if (R) begin
         block_q   <= '0;
         key_q     <= '0;
         cnt       <= '0;
         is_key    <= 1'b0;
         info      <= '0;
         infoCOUNT <= '0;
         doneData  <= 1'b0;
         doneKey   <= 1'b0;
      end else begin
         unique case (state)
            WAIT: begin
               if (accept && hdr_ok) begin
                  info   <= in;
                  is_key <= in[1];
                  cnt    <= '0;
               end
            end
            LOAD: begin
               if (accept) begin
                  cnt <= cnt + 1'b1;
                  if (is_key) key_q   <= {key_q[KW-9:0], in};
                  else        block_q <= {block_q[BW-9:0], in};
                  if (last) begin
                     infoCOUNT <= infoCOUNT + 8'd1;
                     if (is_key) doneKey  <= 1'b1;
                     else        doneData <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (clear) begin
                  doneData <= 1'b0;
                  doneKey  <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef SIMON_DATAIN_ERR_EN
   logic err_q;

   // One-cycle pulse after a dropped header byte.
   always_ff @(posedge clk) begin
      if (R) err_q <= 1'b0;
      else   err_q <= (state == WAIT) && accept && !hdr_ok;
   end

   assign errIN = err_q;
`else
   assign errIN = 1'b0;
`endif

endmodule

// File: tb/tb_simon_data_in.sv
// tb_simon_data_in: table vectors, directed corner sequences and
// randomized frames checked against a frame-level reference model.
module tb_simon_data_in;

   localparam int N = 16;
   localparam int M = 4;
`ifdef SIMON_DATAIN_ERR_EN
   localparam logic ERR = 1'b1;
`else
   localparam logic ERR = 1'b0;
`endif

   logic                clk = 1'b0;
   logic                R;
   logic [7:0]          in_b;
   logic                newIN;
   logic                inREADY;
   logic                readData;
   logic                readKey;
   logic                doneData;
   logic                doneKey;
   logic [1:0][N-1:0]   BLOCK;
   logic [M-1:0][N-1:0] KEY;
   logic [7:0]          info;
   logic [7:0]          infoCOUNT;
   logic                errIN;

   logic [31:0] blk;
   logic [63:0] kv;
   assign blk = BLOCK;
   assign kv  = KEY;

   int checks   = 0;
   int failures = 0;

   logic [31:0] mb;
   logic [63:0] mk;
   logic [7:0]  mcnt;
   logic [7:0]  minfo;

   simon_data_in #(.N(N), .M(M)) dut (
      .clk(clk), .R(R), .in(in_b), .newIN(newIN), .inREADY(inREADY),
      .readData(readData), .readKey(readKey), .doneData(doneData),
      .doneKey(doneKey), .BLOCK(BLOCK), .KEY(KEY), .info(info),
      .infoCOUNT(infoCOUNT), .errIN(errIN)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  hdr;
      logic [63:0] pay;
      logic [31:0] e_blk;
      logic [63:0] e_key;
      logic        e_dd;
      logic        e_dk;
      logic [7:0]  e_cnt;
   } vec_t;

   vec_t tbl[4];

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] b);
      int w;
      w = 0;
      while (!inREADY && w < 20) begin
         tick();
         w++;
      end
      if (!inREADY) begin
         checks++;
         failures++;
         $display("FAIL send_timeout: inREADY got 0 expected 1");
      end
      in_b  = b;
      newIN = 1'b1;
      tick();
      newIN = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] hdr, input logic [63:0] pay,
                             input bit noise);
      int nb;
      nb = hdr[1] ? 8 : 4;
      send(hdr);
      for (int i = nb - 1; i >= 0; i--) begin
         if (noise) begin
            readData = 1'($urandom_range(0, 1));
            readKey  = 1'($urandom_range(0, 1));
         end
         send(pay[i*8 +: 8]);
      end
      readData = 1'b0;
      readKey  = 1'b0;
   endtask

   task automatic consume(input logic key);
      if (key) readKey = 1'b1;
      else     readData = 1'b1;
      tick();
      readKey  = 1'b0;
      readData = 1'b0;
      chk("consume_dd", doneData, 0);
      chk("consume_dk", doneKey, 0);
      chk("consume_rdy", inREADY, 1);
   endtask

   task automatic do_reset();
      R = 1'b1;
      tick();
      R = 1'b0;
   endtask

   task automatic chk_zero(input string nm);
      chk({nm, "_blk"}, blk, 0);
      chk({nm, "_key"}, kv, 0);
      chk({nm, "_info"}, info, 0);
      chk({nm, "_cnt"}, infoCOUNT, 0);
      chk({nm, "_dd"}, doneData, 0);
      chk({nm, "_dk"}, doneKey, 0);
      chk({nm, "_err"}, errIN, 0);
      chk({nm, "_rdy"}, inREADY, 1);
   endtask

   initial begin
      logic [7:0]  hdr;
      logic [63:0] pay;
      logic        key;

      tbl[0] = '{8'h01, 64'h12345678, 32'h12345678, 64'h0, 1, 0, 8'd1};
      tbl[1] = '{8'h02, 64'h0102030405060708, 32'h12345678,
                 64'h0102030405060708, 0, 1, 8'd2};
      tbl[2] = '{8'h45, 64'hDEADBEEF, 32'hDEADBEEF,
                 64'h0102030405060708, 1, 0, 8'd3};
      tbl[3] = '{8'hF6, 64'h1122334455667788, 32'hDEADBEEF,
                 64'h1122334455667788, 0, 1, 8'd4};

      R = 1'b1; in_b = 8'h00; newIN = 1'b0;
      readData = 1'b0; readKey = 1'b0;
      @(negedge clk);
      tick();
      chk_zero("reset");
      R = 1'b0;

      for (int v = 0; v < 4; v++) begin
         send_frame(tbl[v].hdr, tbl[v].pay, 1'b0);
         chk($sformatf("tbl%0d_blk", v), blk, tbl[v].e_blk);
         chk($sformatf("tbl%0d_key", v), kv, tbl[v].e_key);
         chk($sformatf("tbl%0d_dd", v), doneData, tbl[v].e_dd);
         chk($sformatf("tbl%0d_dk", v), doneKey, tbl[v].e_dk);
         chk($sformatf("tbl%0d_cnt", v), infoCOUNT, tbl[v].e_cnt);
         chk($sformatf("tbl%0d_info", v), info, tbl[v].hdr);
         chk($sformatf("tbl%0d_rdy", v), inREADY, 0);
         consume(tbl[v].e_dk);
      end

      // backpressure in HOLD, wrong-type read, read with newIN
      send_frame(8'h01, 64'hA1B2C3D4, 1'b0);
      in_b = 8'h01; newIN = 1'b1;
      repeat (5) tick();
      chk("bp_dd", doneData, 1);
      chk("bp_rdy", inREADY, 0);
      chk("bp_blk", blk, 32'hA1B2C3D4);
      chk("bp_cnt", infoCOUNT, 5);
      readKey = 1'b1;
      tick();
      readKey = 1'b0;
      chk("bp_wrongread_dd", doneData, 1);
      chk("bp_wrongread_rdy", inREADY, 0);
      readData = 1'b1;
      tick();
      readData = 1'b0;
      chk("bp_clear_dd", doneData, 0);
      chk("bp_clear_rdy", inREADY, 1);
      tick();
      newIN = 1'b0;
      chk("bp_hdr_info", info, 8'h01);
      send(8'h10); send(8'h20); send(8'h30); send(8'h40);
      chk("bp_next_blk", blk, 32'h10203040);
      chk("bp_next_dd", doneData, 1);
      chk("bp_next_cnt", infoCOUNT, 6);
      consume(1'b0);

      // invalid header
      send(8'h03);
      chk("inv_err", errIN, ERR);
      chk("inv_info", info, 8'h01);
      chk("inv_cnt", infoCOUNT, 6);
      chk("inv_rdy", inREADY, 1);
      tick();
      chk("inv_err_off", errIN, 0);
      send_frame(8'h01, 64'h0BADF00D, 1'b0);
      chk("inv_after_blk", blk, 32'h0BADF00D);
      chk("inv_after_dd", doneData, 1);
      chk("inv_after_cnt", infoCOUNT, 7);
      consume(1'b0);

      // reset mid-frame
      send(8'h01); send(8'h55); send(8'h66);
      do_reset();
      chk_zero("midrst");
      send_frame(8'h01, 64'h9ABCDEF0, 1'b0);
      chk("midrst_blk", blk, 32'h9ABCDEF0);
      chk("midrst_dd", doneData, 1);
      chk("midrst_cnt", infoCOUNT, 1);
      chk("midrst_key", kv, 0);
      consume(1'b0);

      // randomized frames against the frame-level model
      do_reset();
      mb = '0; mk = '0; mcnt = '0; minfo = '0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(0, 3) == 0) begin
            hdr = 8'($urandom);
            hdr[0] = hdr[1];
            send(hdr);
            chk("rnd_inv_err", errIN, ERR);
            chk("rnd_inv_info", info, minfo);
         end
         key = 1'($urandom_range(0, 1));
         hdr = 8'($urandom);
         hdr[1:0] = key ? 2'b10 : 2'b01;
         pay = {32'($urandom), 32'($urandom)};
         if (!key) pay[63:32] = '0;
         send_frame(hdr, pay, 1'b1);
         minfo = hdr;
         mcnt  = mcnt + 8'd1;
         if (key) mk = pay;
         else     mb = pay[31:0];
         chk("rnd_blk", blk, mb);
         chk("rnd_key", kv, mk);
         chk("rnd_dd", doneData, !key);
         chk("rnd_dk", doneKey, key);
         chk("rnd_info", info, minfo);
         chk("rnd_cnt", infoCOUNT, mcnt);
         if (i == 255) chk("wrap_cnt", infoCOUNT, 0);
         repeat ($urandom_range(0, 2)) tick();
         consume(key);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
